regfile_sb: RTL and testbench

//  Parametrised integer register file with NRD read ports, two write ports and a per-register

---
 rtl/regfile_sb.sv | 118 +++++++++++
 tb/tb_regfile_sb.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// Register file with NRD combinational read ports, two write ports
// (A: ALU/writeback, B: load return) and a per-register load scoreboard.
// Index 0 is hardwired to zero: never written, never marked busy.
// There is no valid/ready handshake here. Every enable (wa_en_i, wb_en_i,
// mark_i) is a single-cycle strobe that is acted on at the next rising edge.
module regfile_sb #(
  parameter  int XLEN   = 32,
  parameter  int NREGS  = 32,
  parameter  int NRD    = 2,
  parameter  int BYPASS = 1,
  localparam int AW     = $clog2(NREGS)
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic [NRD*AW-1:0]   rs_idx_i,
  output logic [NRD*XLEN-1:0] rs_data_o,
  output logic [NRD-1:0]      rs_busy_o,
  input  logic                wa_en_i,
  input  logic [AW-1:0]       wa_idx_i,
  input  logic [XLEN-1:0]     wa_data_i,
  input  logic                wb_en_i,
  input  logic [AW-1:0]       wb_idx_i,
  input  logic [XLEN-1:0]     wb_data_i,
  input  logic                mark_i,
  input  logic [AW-1:0]       mark_idx_i,
  output logic [NREGS-1:0]    busy_o,
  output logic                err_o,
  input  logic [AW-1:0]       dbg_idx_i,
  output logic [XLEN-1:0]     dbg_data_o
);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_next;
  logic             err;
  logic             err_event;

  logic wa_live;
  logic wb_live;
  logic mark_live;

  // Writes and marks aimed at index 0 are dropped everywhere.
  assign wa_live   = wa_en_i && (wa_idx_i != '0);
  assign wb_live   = wb_en_i && (wb_idx_i != '0);
  assign mark_live = mark_i  && (mark_idx_i != '0);

  // Read ports: index 0 reads zero; port A bypass has priority over port B
  // because port A data is what gets stored when both ports hit one index.
  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] idx;
    logic          wa_hit;
    logic          wb_hit;
    logic          mk_hit;

    assign idx    = rs_idx_i[k*AW +: AW];
    assign wa_hit = (BYPASS != 0) && wa_en_i && (wa_idx_i == idx);
    assign wb_hit = (BYPASS != 0) && wb_en_i && (wb_idx_i == idx);
    assign mk_hit = mark_i && (mark_idx_i == idx);

    assign rs_data_o[k*XLEN +: XLEN] = (idx == '0) ? '0        :
                                       wa_hit      ? wa_data_i :
                                       wb_hit      ? wb_data_i :
                                                     regs[idx];
    // A same-cycle load return already satisfies the reader, unless a new
    // load to the same register is issued in that cycle.
    assign rs_busy_o[k] = (wb_hit && !mk_hit) ? 1'b0 : busy[idx];
  end

  // Scoreboard next state: a mark outranks the clear from a load return.
  always_comb begin
    busy_next = busy;
    if (wb_live)   busy_next[wb_idx_i]   = 1'b0;
    if (mark_live) busy_next[mark_idx_i] = 1'b1;
    busy_next[0] = 1'b0;
  end

  // Hazard-protocol violations detected against the current scoreboard.
  always_comb begin
    err_event = 1'b0;
    if (wa_live && busy[wa_idx_i])
      err_event = 1'b1;
    if (wb_live && !busy[wb_idx_i])
      err_event = 1'b1;
    if (mark_live && busy[mark_idx_i] && !(wb_en_i && (wb_idx_i == mark_idx_i)))
      err_event = 1'b1;
  end

  // Register storage; port A is applied last so it wins a same-index collision.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      if (wb_live) regs[wb_idx_i] <= wb_data_i;
      if (wa_live) regs[wa_idx_i] <= wa_data_i;
    end
  end

  // Scoreboard and sticky error flag.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      busy <= '0;
      err  <= 1'b0;
    end else begin
      busy <= busy_next;
      err  <= err | err_event;
    end
  end

  // Debug read: registered, shows the stored value before this edge's writes.
  always_ff @(posedge clk_i) begin
    if (reset_i) dbg_data_o <= '0;
    else         dbg_data_o <= regs[dbg_idx_i];
  end

  assign busy_o = busy;
  assign err_o  = err;

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: one bypassing instance and one non-bypassing
// instance share every input; both are compared each cycle with a
// behavioural model of registers, scoreboard and error flag.
module tb_regfile_sb;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int AW    = $clog2(NREGS);

  logic                clk = 1'b0;
  logic                reset;
  logic [NRD*AW-1:0]   rs_idx;
  logic [NRD*XLEN-1:0] rs_data1, rs_data0;
  logic [NRD-1:0]      rs_busy1, rs_busy0;
  logic                wa_en, wb_en, mark;
  logic [AW-1:0]       wa_idx, wb_idx, mark_idx, dbg_idx;
  logic [XLEN-1:0]     wa_data, wb_data;
  logic [NREGS-1:0]    busy1, busy0;
  logic                err1, err0;
  logic [XLEN-1:0]     dbg1, dbg0;

  // Behavioural model state
  logic [XLEN-1:0]  m_regs [NREGS];
  logic [NREGS-1:0] m_busy;
  logic             m_err;
  logic [XLEN-1:0]  exp_q [$];
  logic [XLEN-1:0]  exp_dbg;
  logic             dbg_valid;

  int pass_cnt = 0;
  int total    = 0;

  regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .BYPASS(1)) dut_byp (
    .clk_i(clk), .reset_i(reset), .rs_idx_i(rs_idx), .rs_data_o(rs_data1),
    .rs_busy_o(rs_busy1), .wa_en_i(wa_en), .wa_idx_i(wa_idx), .wa_data_i(wa_data),
    .wb_en_i(wb_en), .wb_idx_i(wb_idx), .wb_data_i(wb_data), .mark_i(mark),
    .mark_idx_i(mark_idx), .busy_o(busy1), .err_o(err1), .dbg_idx_i(dbg_idx),
    .dbg_data_o(dbg1)
  );

  regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .BYPASS(0)) dut_nobyp (
    .clk_i(clk), .reset_i(reset), .rs_idx_i(rs_idx), .rs_data_o(rs_data0),
    .rs_busy_o(rs_busy0), .wa_en_i(wa_en), .wa_idx_i(wa_idx), .wa_data_i(wa_data),
    .wb_en_i(wb_en), .wb_idx_i(wb_idx), .wb_data_i(wb_data), .mark_i(mark),
    .mark_idx_i(mark_idx), .busy_o(busy0), .err_o(err0), .dbg_idx_i(dbg_idx),
    .dbg_data_o(dbg0)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    total++;
    assert (obs === exp_v) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
  endtask

  task automatic idle();
    wa_en = 1'b0; wb_en = 1'b0; mark = 1'b0;
    wa_idx = '0; wb_idx = '0; mark_idx = '0;
    wa_data = '0; wb_data = '0;
  endtask

  function automatic logic [AW-1:0] rd_idx(input int k);
    return rs_idx[k*AW +: AW];
  endfunction

  // Compare every output of both instances with the model.
  task automatic check_outputs();
    logic [AW-1:0]   idx;
    logic [XLEN-1:0] stored;
    logic [XLEN-1:0] seen;
    logic            ret_now;
    for (int k = 0; k < NRD; k++) begin
      idx     = rd_idx(k);
      stored  = (idx == 0) ? '0 : m_regs[idx];
      seen    = stored;
      ret_now = wb_en && (wb_idx == idx) && !(mark && (mark_idx == idx));
      if (idx != 0 && wa_en && wa_idx == idx)      seen = wa_data;
      else if (idx != 0 && wb_en && wb_idx == idx) seen = wb_data;
      chk($sformatf("rd_byp[%0d] x%0d", k, idx), rs_data1[k*XLEN +: XLEN], seen);
      chk($sformatf("rd_nob[%0d] x%0d", k, idx), rs_data0[k*XLEN +: XLEN], stored);
      chk($sformatf("rbusy_byp[%0d]", k), rs_busy1[k], m_busy[idx] && !ret_now);
      chk($sformatf("rbusy_nob[%0d]", k), rs_busy0[k], m_busy[idx]);
    end
    chk("busy_byp", busy1, m_busy);
    chk("busy_nob", busy0, m_busy);
    chk("err_byp", err1, m_err);
    chk("err_nob", err0, m_err);
    if (dbg_valid) begin
      chk("dbg_byp", dbg1, exp_dbg);
      chk("dbg_nob", dbg0, exp_dbg);
    end
  endtask

  // Apply one clock edge to the model using the inputs currently driven.
  task automatic model_update();
    logic viol;
    exp_q.push_back(reset ? '0 : m_regs[dbg_idx]);
    if (reset) begin
      for (int i = 0; i < NREGS; i++) m_regs[i] = '0;
      m_busy = '0;
      m_err  = 1'b0;
    end else begin
      viol = (wa_en && wa_idx != 0 && m_busy[wa_idx]) ||
             (wb_en && wb_idx != 0 && !m_busy[wb_idx]) ||
             (mark && mark_idx != 0 && m_busy[mark_idx] && !(wb_en && wb_idx == mark_idx));
      m_err = m_err || viol;
      if (wb_en && wb_idx != 0) begin
        m_regs[wb_idx] = wb_data;
        m_busy[wb_idx] = 1'b0;
      end
      if (wa_en && wa_idx != 0) m_regs[wa_idx] = wa_data;
      if (mark && mark_idx != 0) m_busy[mark_idx] = 1'b1;
    end
  endtask

  // One cycle: compare at the falling edge, advance model at the rising edge.
  task automatic step(input bit do_check);
    @(negedge clk);
    dbg_valid = (exp_q.size() != 0);
    if (dbg_valid) exp_dbg = exp_q.pop_front();
    if (do_check) check_outputs();
    @(posedge clk);
    model_update();
    #1;
  endtask

  initial begin
    dbg_valid = 1'b0;
    exp_dbg   = '0;
    m_busy    = '0;
    m_err     = 1'b0;
    for (int i = 0; i < NREGS; i++) m_regs[i] = '0;
    idle();
    rs_idx  = '0;
    dbg_idx = '0;
    reset   = 1'b1;
    step(0);
    step(0);
    reset = 1'b0;

    // Reset clears a written register, scoreboard, error and debug output
    wa_en = 1'b1; wa_idx = 5; wa_data = 32'hDEADBEEF;
    dbg_idx = 5;
    step(1);
    idle();
    rs_idx = {5'd0, 5'd5};
    #1 chk("x5_written", rs_data0[XLEN-1:0], 32'hDEADBEEF);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    #1;
    chk("rst_x5", rs_data1[XLEN-1:0], 32'h0);
    chk("rst_busy", busy1, '0);
    chk("rst_err", err1, 1'b0);
    chk("rst_dbg", dbg1, 32'h0);

    // Index 0 ignores writes and marks
    wa_en = 1'b1; wa_idx = 0; wa_data = 32'hFFFFFFFF;
    mark = 1'b1; mark_idx = 0;
    rs_idx = '0;
    #1 chk("x0_same_cycle", rs_data1[XLEN-1:0], 32'h0);
    step(1);
    idle();
    #1;
    chk("x0_read", rs_data1[XLEN-1:0], 32'h0);
    chk("x0_busy", busy1[0], 1'b0);
    chk("x0_err", err1, 1'b0);

    // Bypass versus stored-only reads
    wa_en = 1'b1; wa_idx = 3; wa_data = 32'h12345678;
    rs_idx = {5'd0, 5'd3};
    #1;
    chk("byp_same_cycle", rs_data1[XLEN-1:0], 32'h12345678);
    chk("nobyp_old", rs_data0[XLEN-1:0], 32'h0);
    step(1);
    idle();
    #1 chk("nobyp_next", rs_data0[XLEN-1:0], 32'h12345678);

    // Scoreboard mark then load return
    mark = 1'b1; mark_idx = 7;
    step(1);
    idle();
    rs_idx = {5'd7, 5'd0};
    repeat (3) step(1);
    chk("x7_busy", rs_busy1[1], 1'b1);
    wb_en = 1'b1; wb_idx = 7; wb_data = 32'hA5A5A5A5;
    #1 chk("x7_ret_byp_busy", rs_busy1[1], 1'b0);
    step(1);
    idle();
    #1;
    chk("x7_busy_clr", busy1[7], 1'b0);
    chk("x7_data", rs_data1[2*XLEN-1:XLEN], 32'hA5A5A5A5);
    chk("x7_err", err1, 1'b0);

    // Port collision on a busy register: port A wins, WAW raises err
    mark = 1'b1; mark_idx = 9;
    step(1);
    idle();
    wa_en = 1'b1; wa_idx = 9; wa_data = 32'h1;
    wb_en = 1'b1; wb_idx = 9; wb_data = 32'h2;
    step(1);
    idle();
    rs_idx = {5'd0, 5'd9};
    #1;
    chk("x9_data", rs_data1[XLEN-1:0], 32'h1);
    chk("x9_err", err1, 1'b1);
    reset = 1'b1;
    step(1);
    reset = 1'b0;

    // Mark and return to the same register in one cycle
    mark = 1'b1; mark_idx = 4;
    step(1);
    wb_en = 1'b1; wb_idx = 4; wb_data = 32'h44;
    step(1);
    idle();
    rs_idx = {5'd4, 5'd0};
    #1;
    chk("x4_data", rs_data0[2*XLEN-1:XLEN], 32'h44);
    chk("x4_busy", busy1[4], 1'b1);
    chk("x4_err", err1, 1'b0);

    // Spurious load return: sticky error until reset
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    wb_en = 1'b1; wb_idx = 6; wb_data = 32'h66;
    step(1);
    idle();
    #1 chk("spur_err", err1, 1'b1);
    repeat (10) step(1);
    chk("spur_sticky", err1, 1'b1);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    #1 chk("spur_cleared", err1, 1'b0);

    // Double issue to x8
    mark = 1'b1; mark_idx = 8;
    step(1);
    step(1);
    idle();
    #1 chk("dbl_mark_err", err1, 1'b1);

    // Randomised traffic on a narrow index range to provoke collisions
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    for (int n = 0; n < 400; n++) begin
      reset    = ($urandom_range(0, 49) == 0);
      wa_en    = $urandom_range(0, 1);
      wa_idx   = AW'($urandom_range(0, 7));
      wa_data  = $urandom;
      wb_en    = ($urandom_range(0, 2) == 0);
      wb_idx   = AW'($urandom_range(0, 7));
      wb_data  = $urandom;
      mark     = ($urandom_range(0, 2) == 0);
      mark_idx = AW'($urandom_range(0, 7));
      rs_idx   = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))};
      dbg_idx  = AW'($urandom_range(0, 7));
      step(1);
    end
    reset = 1'b0;
    idle();
    step(1);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
